// File: rtl/disp_pkg.sv
// Shared constants for the display scan slice.
//   SEG_0..SEG_9 : active-low segment patterns, bit 6 = a ... bit 0 = g
//   SEG_OFF      : all segments dark
//   ST_BLANK/ST_DRIVE : scan FSM state encoding
package disp_pkg;

  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Load/ack handshake between the BCD datapath and the scan controller.
//   load       : one-cycle strobe, capture value_in
//   value_in   : N_DIGITS BCD nibbles, digit 0 in bits [3:0]
//   ack        : pulse when a pending value becomes displayed
//   frame_done : pulse at the start of each scan frame
// master = datapath side, slave = display_scan_ctrl.
interface display_scan_ctrl_if #(
  parameter int unsigned N_DIGITS = 4
) ();

  logic                    load;
  logic [4*N_DIGITS-1:0]   value_in;
  logic                    ack;
  logic                    frame_done;

  modport master (
    output load,
    output value_in,
    input  ack,
    input  frame_done
  );

  modport slave (
    input  load,
    input  value_in,
    output ack,
    output frame_done
  );

endinterface

// File: rtl/display_scan_ctrl_bcd2.sv
// bcd2: BCD digit to active-low 7-segment pattern.
//   bcd : digit value 0..15
//   seg : pattern, bit 6 = a ... bit 0 = g; non-decimal values give SEG_OFF
module bcd2
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for an N-digit
// common-anode 7-segment display with tear-free load/ack updates.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of the load/value_in/ack/frame_done handshake
//   an       : active-low anode enables, an[k] drives digit k
//   seg      : active-low segments, seg[6] = a ... seg[0] = g
// Every scan slot is DEAD_CYCLES of all-off followed by REFRESH_DIV cycles
// driving one digit; digits are scanned 0..N_DIGITS-1. A pending value is
// moved into the display register only at the frame boundary.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter int unsigned DEAD_CYCLES   = 2,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  display_scan_ctrl_if.slave   bus,
  output logic [N_DIGITS-1:0]  an,
  output logic [6:0]           seg
);

  localparam int unsigned PMAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int unsigned PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int unsigned IW   = $clog2(N_DIGITS);

  localparam logic [PW-1:0] PRE_BLANK_LAST = PW'(DEAD_CYCLES - 1);
  localparam logic [PW-1:0] PRE_DRIVE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST       = IW'(N_DIGITS - 1);

  logic [0:0]              state, state_n;
  logic [PW-1:0]           pre, pre_n;
  logic [IW-1:0]           idx, idx_n;
  logic                    xfer;

  logic [4*N_DIGITS-1:0]   disp_reg;
  logic [4*N_DIGITS-1:0]   pend_reg;
  logic                    pend_flag;

  logic [N_DIGITS-1:0]     zero_above;
  logic                    za;
  logic [3:0]              nib;
  logic [6:0]              dec;
  logic                    blank_lead;
  logic [N_DIGITS-1:0]     an_n;
  logic [6:0]              seg_n;

  // Scan sequencing; xfer marks the edge that enters the frame boundary.
  always_comb begin
    state_n = state;
    pre_n   = pre + 1'b1;
    idx_n   = idx;
    xfer    = 1'b0;
    case (state)
      ST_BLANK: begin
        if (pre == PRE_BLANK_LAST) begin
          state_n = ST_DRIVE;
          pre_n   = '0;
        end
      end
      ST_DRIVE: begin
        if (pre == PRE_DRIVE_LAST) begin
          state_n = ST_BLANK;
          pre_n   = '0;
          if (idx == IDX_LAST) begin
            idx_n = '0;
            xfer  = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_BLANK;
        pre_n   = '0;
      end
    endcase
  end

  // zero_above[k]: digit k and every more significant digit are zero.
  always_comb begin
    zero_above = '0;
    za         = 1'b1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      za = 1'b1;
      for (int unsigned j = k; j < N_DIGITS; j++) begin
        if (disp_reg[4*j +: 4] != 4'd0) za = 1'b0;
      end
      zero_above[k] = za;
    end
  end

  // Outputs are decoded from the next state and registered, so the pins
  // line up with the state they describe while still coming from flops.
  // disp_reg only changes when entering BLANK, so it is valid for DRIVE.
  assign nib = disp_reg[{idx_n, 2'b00} +: 4];

  bcd2 u_bcd2 (
    .bcd (nib),
    .seg (dec)
  );

  always_comb begin
    blank_lead = (BLANK_LEADING != 0) && (idx_n != '0) && zero_above[idx_n];
    if (state_n == ST_DRIVE) begin
      an_n  = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_n);
      seg_n = blank_lead ? SEG_OFF : dec;
    end else begin
      an_n  = '1;
      seg_n = SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_BLANK;
      pre            <= '0;
      idx            <= '0;
      disp_reg       <= '0;
      pend_reg       <= '0;
      pend_flag      <= 1'b0;
      an             <= '1;
      seg            <= SEG_OFF;
      bus.ack        <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_n;
      pre            <= pre_n;
      idx            <= idx_n;
      an             <= an_n;
      seg            <= seg_n;
      bus.frame_done <= xfer;
      bus.ack        <= xfer && pend_flag;
      if (xfer && pend_flag) disp_reg <= pend_reg;
      // A load coinciding with the transfer edge moves the old value out
      // and leaves the new one pending for the following frame.
      if (bus.load) begin
        pend_reg  <= bus.value_in;
        pend_flag <= 1'b1;
      end else if (xfer) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule
